// File: rtl/pf_lanectrl_pause_sync_mc_pkg.sv
// Shared definitions for the pause-lane controller.
// Holds the per-lane state encoding, the hold-counter width and the legal
// ranges of the top-level parameters.
package pf_lanectrl_pause_sync_mc_pkg;

    // Per-lane conditioning state.
    typedef enum logic [1:0] {
        LANE_IDLE   = 2'd0,
        LANE_HOLD   = 2'd1,
        LANE_ACTIVE = 2'd2
    } lane_state_e;

    // Width of the minimum-pulse down-counter (covers MIN_PULSE up to 15).
    localparam int CNT_W = 4;

    // Legal parameter ranges.
    localparam int NUM_LANES_MIN   = 1;
    localparam int NUM_LANES_MAX   = 8;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int MIN_PULSE_MIN   = 1;
    localparam int MIN_PULSE_MAX   = 15;

endpackage

// File: rtl/pf_lanectrl_pause_sync_mc_lane.sv
// One pause lane: synchroniser, minimum-width FSM, sticky stretch flag and an
// optional falling-edge output flop.
// Ports:
//   CLK          lane-control clock
//   RESET        asynchronous, active-high reset
//   pause_i      raw pause request, asynchronous to CLK
//   mask_i       1 allows the lane to start a new pause
//   ext_clr_i    synchronous clear of the sticky flag
//   pause_sync_o synchronised, width-conditioned pause
//   ext_flag_o   sticky: a pulse shorter than MIN_PULSE was stretched
module pf_lanectrl_pause_lane
    import pf_lanectrl_pause_sync_mc_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_PULSE     = 2,
    parameter int FALL_EDGE_OUT = 0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic pause_i,
    input  logic mask_i,
    input  logic ext_clr_i,
    output logic pause_sync_o,
    output logic ext_flag_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    (* syn_keep = 1 *) logic [SYNC_STAGES-1:0] sync_q;
    (* syn_keep = 1 *) logic                   out_q;
    lane_state_e                               state_q;
    logic [CNT_W-1:0]                          cnt_q;
    logic                                      flag_q;
    logic                                      s_lvl;

    // Synchroniser: the last stage is the level the FSM acts on.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pause_i};
        end
    end

    assign s_lvl = sync_q[SYNC_STAGES-1];

    // Minimum-width FSM. out_q follows the next state (high in HOLD/ACTIVE),
    // so it moves on the same edge as the state. The input level is ignored
    // while the counter runs; only the value seen at CNT=0 decides whether
    // the pause continues.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= LANE_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            // Clear first; a set in the HOLD branch below takes priority.
            if (ext_clr_i) begin
                flag_q <= 1'b0;
            end
            case (state_q)
                LANE_IDLE: begin
                    if (s_lvl && mask_i) begin
                        state_q <= LANE_HOLD;
                        cnt_q   <= CNT_LOAD;
                        out_q   <= 1'b1;
                    end else begin
                        out_q   <= 1'b0;
                    end
                end
                LANE_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q   <= cnt_q - CNT_ONE;
                        out_q   <= 1'b1;
                    end else if (s_lvl) begin
                        state_q <= LANE_ACTIVE;
                        out_q   <= 1'b1;
                    end else begin
                        // Input already gone: this pulse was stretched.
                        state_q <= LANE_IDLE;
                        out_q   <= 1'b0;
                        flag_q  <= 1'b1;
                    end
                end
                LANE_ACTIVE: begin
                    if (s_lvl) begin
                        out_q   <= 1'b1;
                    end else begin
                        state_q <= LANE_IDLE;
                        out_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= LANE_IDLE;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ext_flag_o = flag_q;

    // Optional half-cycle retiming of the output onto the falling edge.
    generate
        if (FALL_EDGE_OUT != 0) begin : g_fall
            (* syn_keep = 1 *) logic fall_q;
            always_ff @(negedge CLK or posedge RESET) begin
                if (RESET) begin
                    fall_q <= 1'b0;
                end else begin
                    fall_q <= out_q;
                end
            end
            assign pause_sync_o = fall_q;
        end else begin : g_rise
            assign pause_sync_o = out_q;
        end
    endgenerate

endmodule

// File: rtl/pf_lanectrl_pause_sync_mc.sv
// Multi-lane pause synchroniser with minimum output pulse width.
// Ports:
//   CLK                  lane-control clock
//   RESET                asynchronous, active-high reset
//   HS_IO_CLK_PAUSE      per-lane raw pause request (asynchronous)
//   PAUSE_MASK           per-lane start enable (synchronous)
//   EXT_CLR              synchronous clear of all EXT_FLAG bits
//   HS_IO_CLK_PAUSE_SYNC per-lane synchronised, width-conditioned pause
//   EXT_FLAG             per-lane sticky "pulse was stretched" flag
//   PAUSE_ACTIVE         OR of all HS_IO_CLK_PAUSE_SYNC bits
module pf_lanectrl_pause_sync_mc
    import pf_lanectrl_pause_sync_mc_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_PULSE     = 2,
    parameter int FALL_EDGE_OUT = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
    input  logic [NUM_LANES-1:0] PAUSE_MASK,
    input  logic                 EXT_CLR,
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
    output logic [NUM_LANES-1:0] EXT_FLAG,
    output logic                 PAUSE_ACTIVE
);

    // Lanes are fully independent; nothing is shared between them.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi = gi + 1) begin : g_lane
            pf_lanectrl_pause_lane #(
                .SYNC_STAGES   (SYNC_STAGES),
                .MIN_PULSE     (MIN_PULSE),
                .FALL_EDGE_OUT (FALL_EDGE_OUT)
            ) u_lane (
                .CLK          (CLK),
                .RESET        (RESET),
                .pause_i      (HS_IO_CLK_PAUSE[gi]),
                .mask_i       (PAUSE_MASK[gi]),
                .ext_clr_i    (EXT_CLR),
                .pause_sync_o (HS_IO_CLK_PAUSE_SYNC[gi]),
                .ext_flag_o   (EXT_FLAG[gi])
            );
        end
    endgenerate

    // Straight OR of the final output flops, no added latency.
    assign PAUSE_ACTIVE = |HS_IO_CLK_PAUSE_SYNC;

endmodule

// File: tb/tb_pf_lanectrl_pause_sync_mc.sv
module tb_pf_lanectrl_pause_sync_mc;

    localparam int NL = 4;
    // Three configurations: A (SS=2, MP=2), B (SS=2, MP=5), C (SS=3, MP=2, falling-edge out)
    localparam int MP [3] = '{2, 5, 2};
    localparam int SS [3] = '{2, 2, 3};

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [NL-1:0] raw = '0;
    logic [NL-1:0] mask = '1;
    logic          ext_clr = 1'b0;

    logic [NL-1:0] sync_a, flag_a, sync_b, flag_b, sync_c, flag_c;
    logic          act_a, act_b, act_c;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(2), .MIN_PULSE(2), .FALL_EDGE_OUT(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(raw), .PAUSE_MASK(mask), .EXT_CLR(ext_clr),
        .HS_IO_CLK_PAUSE_SYNC(sync_a), .EXT_FLAG(flag_a), .PAUSE_ACTIVE(act_a));

    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(2), .MIN_PULSE(5), .FALL_EDGE_OUT(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(raw), .PAUSE_MASK(mask), .EXT_CLR(ext_clr),
        .HS_IO_CLK_PAUSE_SYNC(sync_b), .EXT_FLAG(flag_b), .PAUSE_ACTIVE(act_b));

    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(3), .MIN_PULSE(2), .FALL_EDGE_OUT(1)) dut_c (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(raw), .PAUSE_MASK(mask), .EXT_CLR(ext_clr),
        .HS_IO_CLK_PAUSE_SYNC(sync_c), .EXT_FLAG(flag_c), .PAUSE_ACTIVE(act_c));

    // ---------------- behavioural reference model ----------------
    // hist[d] = raw value sampled d+1 edges ago (before the current edge).
    logic [NL-1:0] hist [8];
    bit m_on   [3][NL];
    bit m_prev [3][NL];
    bit m_flag [3][NL];
    int m_start[3][NL];
    int cyc = 0;

    task automatic model_reset();
        for (int d = 0; d < 8; d++) hist[d] = '0;
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < NL; l++) begin
                m_on[k][l] = 0; m_prev[k][l] = 0; m_flag[k][l] = 0; m_start[k][l] = 0;
            end
        end
    endtask

    // One rising edge: a pulse starts when the synchronised level is high and
    // the lane is enabled; once started it lasts at least MP cycles and then
    // follows the synchronised level. Ending exactly at MP means stretched.
    task automatic model_step();
        bit s, set;
        if (RESET) return;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < NL; l++) begin
                m_prev[k][l] = m_on[k][l];
                s   = hist[SS[k]-1][l];
                set = 0;
                if (!m_on[k][l]) begin
                    if (s && mask[l]) begin
                        m_on[k][l]    = 1;
                        m_start[k][l] = cyc;
                    end
                end else if (cyc - m_start[k][l] >= MP[k]) begin
                    if (!s) begin
                        m_on[k][l] = 0;
                        if (cyc - m_start[k][l] == MP[k]) set = 1;
                    end
                end
                if (set) m_flag[k][l] = 1;
                else if (ext_clr) m_flag[k][l] = 0;
            end
        end
        for (int d = 7; d > 0; d--) hist[d] = hist[d-1];
        hist[0] = raw;
    endtask

    function automatic logic [NL-1:0] exp_out(int k);
        logic [NL-1:0] v;
        for (int l = 0; l < NL; l++) v[l] = (k == 2) ? m_prev[k][l] : m_on[k][l];
        return v;
    endfunction

    function automatic logic [NL-1:0] exp_flag(int k);
        logic [NL-1:0] v;
        for (int l = 0; l < NL; l++) v[l] = m_flag[k][l];
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic settle();
        raw = '0; mask = '1; ext_clr = 1'b0;
        repeat (8) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [6*NL-1:0] all_out;
        RESET = 1'b1; raw = '0; mask = '1; ext_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        all_out = {sync_a, flag_a, sync_b, flag_b, sync_c, flag_c};
        total++;
        if (all_out !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        total++;
        if ({act_a, act_b, act_c} !== 3'b000) begin
            bad++; $display("FAIL reset_pause_active got=%b exp=000", {act_a, act_b, act_c});
        end
        #2 RESET = 1'b0;
        $display("test_reset: outputs=%h", all_out);
    endtask

    task automatic test_short_pulse();
        int rise_a = -1, wid_a = 0, rise_b = -1, wid_b = 0;
        settle();
        raw[0] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 0) raw[0] = 1'b0;
            if (sync_a[0]) begin if (rise_a < 0) rise_a = i; wid_a++; end
            if (sync_b[0]) begin if (rise_b < 0) rise_b = i; wid_b++; end
        end
        total++;
        if (rise_a !== 2) begin bad++; $display("FAIL short_rise_a got=%0d exp=2", rise_a); end
        total++;
        if (wid_a !== 2) begin bad++; $display("FAIL short_width_a got=%0d exp=2", wid_a); end
        total++;
        if (wid_b !== 5) begin bad++; $display("FAIL short_width_b got=%0d exp=5", wid_b); end
        total++;
        if (flag_a[0] !== 1'b1) begin bad++; $display("FAIL short_flag_a got=%b exp=1", flag_a[0]); end
        total++;
        if (flag_b[0] !== 1'b1) begin bad++; $display("FAIL short_flag_b got=%b exp=1", flag_b[0]); end
        $display("test_short_pulse: rise=%0d width_a=%0d width_b=%0d", rise_a, wid_a, wid_b);
    endtask

    task automatic test_long_pulse();
        int rise_a = -1, wid_a = 0, wid_b = 0;
        settle();
        raw[1] = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (i == 9) raw[1] = 1'b0;
            if (sync_a[1]) begin if (rise_a < 0) rise_a = i; wid_a++; end
            if (sync_b[1]) wid_b++;
        end
        total++;
        if (rise_a !== 2) begin bad++; $display("FAIL long_rise_a got=%0d exp=2", rise_a); end
        total++;
        if (wid_a !== 10) begin bad++; $display("FAIL long_width_a got=%0d exp=10", wid_a); end
        total++;
        if (wid_b !== 10) begin bad++; $display("FAIL long_width_b got=%0d exp=10", wid_b); end
        total++;
        if (flag_a[1] !== 1'b0) begin bad++; $display("FAIL long_flag_a got=%b exp=0", flag_a[1]); end
        $display("test_long_pulse: rise=%0d width_a=%0d width_b=%0d", rise_a, wid_a, wid_b);
    endtask

    task automatic test_mask();
        int hi2 = 0, wid3 = 0;
        settle();
        mask[2] = 1'b0;
        raw[2] = 1'b1;
        raw[3] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i == 3) raw[2] = 1'b0;
            if (i == 4) mask[3] = 1'b0;  // lane 3 is ACTIVE by now
            if (i == 9) raw[3] = 1'b0;
            if (sync_a[2]) hi2++;
            if (sync_a[3]) wid3++;
        end
        total++;
        if (hi2 !== 0) begin bad++; $display("FAIL mask_lane2_high got=%0d exp=0", hi2); end
        total++;
        if (wid3 !== 10) begin bad++; $display("FAIL mask_lane3_width got=%0d exp=10", wid3); end
        mask = '1;
        $display("test_mask: lane2_high=%0d lane3_width=%0d", hi2, wid3);
    endtask

    task automatic test_hold_glitch();
        int wid_b = 0, rises_b = 0;
        logic last = 1'b0;
        settle();
        raw[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) raw[0] = 1'b0;
            if (i == 1) raw[0] = 1'b1;
            if (i == 2) raw[0] = 1'b0;
            if (sync_b[0]) wid_b++;
            if (sync_b[0] && !last) rises_b++;
            last = sync_b[0];
            total++;
            if (sync_b !== exp_out(1)) begin
                bad++; $display("FAIL glitch_model_b cyc=%0d got=%h exp=%h", i, sync_b, exp_out(1));
            end
        end
        total++;
        if (wid_b !== 5) begin bad++; $display("FAIL glitch_width_b got=%0d exp=5", wid_b); end
        total++;
        if (rises_b !== 1) begin bad++; $display("FAIL glitch_pulses_b got=%0d exp=1", rises_b); end
        $display("test_hold_glitch: width=%0d pulses=%0d", wid_b, rises_b);
    endtask

    task automatic test_reset_mid();
        int rise_a = -1, rise_b = -1, rise_c = -1;
        settle();
        raw[1] = 1'b1;
        repeat (8) tick();
        total++;
        if (sync_a[1] !== 1'b1) begin bad++; $display("FAIL rstmid_pre_a got=%b exp=1", sync_a[1]); end
        #2 RESET = 1'b1;
        model_reset();
        #1;
        total++;
        if ({sync_a, sync_b, sync_c} !== '0) begin
            bad++; $display("FAIL rstmid_async_out got=%h exp=0", {sync_a, sync_b, sync_c});
        end
        total++;
        if ({act_a, act_b, act_c} !== 3'b000) begin
            bad++; $display("FAIL rstmid_async_active got=%b exp=000", {act_a, act_b, act_c});
        end
        repeat (2) tick();
        #2 RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sync_a[1] && rise_a < 0) rise_a = i;
            if (sync_b[1] && rise_b < 0) rise_b = i;
            if (sync_c[1] && rise_c < 0) rise_c = i;
        end
        total++;
        if (rise_a !== 2) begin bad++; $display("FAIL rstmid_rise_a got=%0d exp=2", rise_a); end
        total++;
        if (rise_b !== 2) begin bad++; $display("FAIL rstmid_rise_b got=%0d exp=2", rise_b); end
        total++;
        if (rise_c !== 4) begin bad++; $display("FAIL rstmid_rise_c got=%0d exp=4", rise_c); end
        raw[1] = 1'b0;
        $display("test_reset_mid: rise_a=%0d rise_b=%0d rise_c=%0d", rise_a, rise_b, rise_c);
    endtask

    task automatic test_fall_edge_clr();
        settle();
        ext_clr = 1'b1;
        tick();
        ext_clr = 1'b0;
        total++;
        if ({flag_a, flag_b, flag_c} !== '0) begin
            bad++; $display("FAIL clr_all got=%h exp=0", {flag_a, flag_b, flag_c});
        end
        raw[0] = 1'b1;
        tick();                 // first sampling edge e0
        raw[0] = 1'b0;
        repeat (3) tick();      // e0+3: rising-edge register of config C goes high
        total++;
        if (sync_c[0] !== 1'b0) begin bad++; $display("FAIL fall_early_c got=%b exp=0", sync_c[0]); end
        @(negedge CLK);
        #1;
        total++;
        if (sync_c[0] !== 1'b1) begin bad++; $display("FAIL fall_rise_c got=%b exp=1", sync_c[0]); end
        total++;
        if (act_c !== 1'b1) begin bad++; $display("FAIL fall_active_c got=%b exp=1", act_c); end
        tick();                 // e0+4
        ext_clr = 1'b1;         // coincides with the set edge of config C
        tick();                 // e0+5
        ext_clr = 1'b0;
        total++;
        if (flag_c[0] !== 1'b1) begin bad++; $display("FAIL setclr_flag_c got=%b exp=1", flag_c[0]); end
        total++;
        if (flag_a[0] !== 1'b0) begin bad++; $display("FAIL clr_flag_a got=%b exp=0", flag_a[0]); end
        $display("test_fall_edge_clr: flag_c=%b flag_a=%b", flag_c[0], flag_a[0]);
    endtask

    task automatic test_random();
        logic [NL-1:0] gs [3];
        logic [NL-1:0] gf [3];
        logic          ga [3];
        int errs = 0;
        settle();
        for (int i = 0; i < 600; i++) begin
            tick();
            gs[0] = sync_a; gs[1] = sync_b; gs[2] = sync_c;
            gf[0] = flag_a; gf[1] = flag_b; gf[2] = flag_c;
            ga[0] = act_a;  ga[1] = act_b;  ga[2] = act_c;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (gs[k] !== exp_out(k)) begin
                    bad++; errs++; $display("FAIL rand_sync cfg=%0d cyc=%0d got=%h exp=%h", k, i, gs[k], exp_out(k));
                end
                total++;
                if (gf[k] !== exp_flag(k)) begin
                    bad++; errs++; $display("FAIL rand_flag cfg=%0d cyc=%0d got=%h exp=%h", k, i, gf[k], exp_flag(k));
                end
                total++;
                if (ga[k] !== (|exp_out(k))) begin
                    bad++; errs++; $display("FAIL rand_active cfg=%0d cyc=%0d got=%b exp=%b", k, i, ga[k], |exp_out(k));
                end
            end
            for (int l = 0; l < NL; l++) begin
                if ($urandom_range(0, 3) == 0) raw[l] = ~raw[l];
                if ($urandom_range(0, 15) == 0) mask[l] = ~mask[l];
            end
            ext_clr = ($urandom_range(0, 11) == 0);
            if (i == 300) begin
                #2 RESET = 1'b1;
                model_reset();
                repeat (2) tick();
                #2 RESET = 1'b0;
            end
        end
        $display("test_random: cycles=600 errors=%0d", errs);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short_pulse();
        test_long_pulse();
        test_mask();
        test_hold_glitch();
        test_reset_mid();
        test_fall_edge_clr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pf_lanectrl_pause_sync_mc.md
PF_LANECTRL_PAUSE_SYNC_MC -- requirements
Module: pf_lanectrl_pause_sync_mc

Interface
REQ-001 Parameter NUM_LANES, default 4, number of independent pause lanes (legal 1..8).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth in CLK flops (legal 2..4).
REQ-003 Parameter MIN_PULSE, default 2, minimum output-high width in CLK cycles (legal 1..15).
REQ-004 Parameter FALL_EDGE_OUT, default 0; 1 adds a final falling-edge CLK output flop.
REQ-005 CLK  input  1  lane-control clock; all flops use this clock.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 HS_IO_CLK_PAUSE  input  NUM_LANES  per-lane raw pause request, asynchronous to CLK.
REQ-008 PAUSE_MASK  input  NUM_LANES  per-lane enable, synchronous to CLK; 1 means the lane may start a pause.
REQ-009 EXT_CLR  input  1  synchronous clear for EXT_FLAG, all lanes.
REQ-010 HS_IO_CLK_PAUSE_SYNC  output  NUM_LANES  per-lane synchronised, width-conditioned pause.
REQ-011 EXT_FLAG  output  NUM_LANES  sticky per-lane flag: a pulse was stretched to MIN_PULSE.
REQ-012 PAUSE_ACTIVE  output  1  OR of all HS_IO_CLK_PAUSE_SYNC bits.

Function
REQ-013 Each lane shall pass its input through a chain of SYNC_STAGES rising-edge flops; the last stage is the synchronised level S.
REQ-014 Each lane shall have a 3-state FSM: IDLE, HOLD, ACTIVE, plus a 4-bit down-counter CNT.
REQ-015 IDLE: if S=1 and PAUSE_MASK=1, go to HOLD and load CNT=MIN_PULSE-1; otherwise remain in IDLE.
REQ-016 HOLD: if CNT!=0, decrement CNT; if CNT=0, go to ACTIVE when S=1, or to IDLE when S=0.
REQ-017 ACTIVE: remain while S=1; go to IDLE when S=0.
REQ-018 The registered lane output shall be 1 exactly when the next state is HOLD or ACTIVE; it is updated on the same edge as the state.
REQ-019 Latency (FALL_EDGE_OUT=0): output rise shall occur SYNC_STAGES+1 rising edges after the input rise is first sampled; output fall follows the same delay unless held by HOLD.
REQ-020 The output high time shall be at least MIN_PULSE cycles; with MIN_PULSE=1, behaviour equals a plain synchroniser plus one register.
REQ-021 A toggle of S during HOLD shall not affect the output; only S at CNT=0 is evaluated.
REQ-022 PAUSE_MASK shall gate only the IDLE->HOLD transition; deasserting it mid-pulse shall not truncate HOLD or ACTIVE.
REQ-023 EXT_FLAG[i] shall set on a HOLD->IDLE transition (pulse shorter than MIN_PULSE) and shall clear on EXT_CLR=1; simultaneous set and clear resolves to set.
REQ-024 FALL_EDGE_OUT=1: the lane output shall be re-registered on the CLK falling edge, adding half a cycle of latency; there shall be no other behavioural change.
REQ-025 PAUSE_ACTIVE shall be a combinational OR of the final output flops, with no extra latency.
REQ-026 Lanes shall be fully independent; no cross-lane state.

Reset
REQ-027 RESET=1 shall asynchronously clear all synchroniser flops, CNT, EXT_FLAG and output flops (including the falling-edge flop), and force every FSM to IDLE; all outputs read 0.
REQ-028 RESET asserted mid-pulse shall drop the outputs to 0 immediately; after release, a still-high input shall restart via the full synchroniser latency and a full MIN_PULSE HOLD.

Structure
REQ-029 A shared package shall hold the lane state enum (IDLE, HOLD, ACTIVE), the counter width constant (4) and the parameter legal limits.
REQ-030 A sub-module pf_lanectrl_pause_lane shall implement one lane (synchroniser, FSM, CNT, flag, optional falling-edge flop); the top level shall instantiate NUM_LANES of them in a generate loop.
REQ-031 Synchroniser and output flops shall carry syn_keep so that synthesis does not merge or retime them.

Verification
REQ-032 NUM_LANES=4, SYNC_STAGES=2, MIN_PULSE=2: 1-cycle pulse on lane 0 -> output high for exactly 2 cycles, rising 3 edges after sampling; EXT_FLAG[0]=1.
REQ-033 Same configuration, 10-cycle pulse on lane 1 -> output high for 10 cycles, delayed by 3; EXT_FLAG[1] stays 0.
REQ-034 PAUSE_MASK[2]=0 with a pulse on lane 2 -> output stays 0; mask cleared mid-ACTIVE on lane 3 -> lane 3 output continues until its input falls.
REQ-035 MIN_PULSE=5: pulse 1 cycle, low 1 cycle, high 1 cycle during HOLD -> single output pulse of exactly 5 cycles.
REQ-036 RESET asserted during ACTIVE with the input held high -> outputs 0 asynchronously; after release, output returns 3 edges later.
REQ-037 FALL_EDGE_OUT=1, SYNC_STAGES=3 -> output rise lands on the falling edge 3.5 cycles after the first sampling edge; EXT_CLR coincident with a set -> EXT_FLAG remains 1.
